// File: rtl/cla_pkg.sv
// Shared widths and pipeline payload types for the 32-bit pipelined CLA
// adder/subtractor. Flag-related payload fields exist only when the
// CLA_PIPE_FLAGS_EN macro is defined.
package cla_pkg;

  localparam int CLA_WIDTH = 32;
  localparam int CLA_GRP   = 4;
  localparam int CLA_NGRP  = CLA_WIDTH / CLA_GRP;

  // Payload held between operand capture and carry resolution.
  typedef struct packed {
    logic [CLA_WIDTH-1:0] p;
    logic [CLA_WIDTH-1:0] g;
    logic [CLA_NGRP-1:0]  grp_p;
    logic [CLA_NGRP-1:0]  grp_g;
    logic                 c0;
`ifdef CLA_PIPE_FLAGS_EN
    logic                 a_msb;
    logic                 b_msb;
`endif
  } s1_pay_t;

  // Payload presented on the result port.
  typedef struct packed {
    logic [CLA_WIDTH-1:0] sum;
    logic                 cout;
`ifdef CLA_PIPE_FLAGS_EN
    logic                 zero;
    logic                 neg;
    logic                 ovf;
`endif
  } s2_pay_t;

endpackage

// File: rtl/cla_pipe_adder32_lcu4.sv
// 4-bit lookahead carry unit: ripple-free carries for four positions plus
// block propagate/generate for the next lookahead level.
module lcu4 (
  input  logic       c_in,
  input  logic [3:0] p,
  input  logic [3:0] g,
  output logic [4:1] carry,
  output logic       p_out,
  output logic       g_out
);

  // Two-level sum-of-products carries and block P/G.
  always_comb begin
    carry[1] = g[0] | (p[0] & c_in);
    carry[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    carry[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_in);
    carry[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_in);
    p_out    = &p;
    g_out    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/cla_pipe_adder32.sv
// Two-stage pipelined 32-bit carry-lookahead adder/subtractor with
// valid/ready on both sides. Stage 1 captures bit and group P/G; stage 2
// resolves group carries with a section lookahead and forms the sum.
// Optional result flags are built only when CLA_PIPE_FLAGS_EN is defined;
// otherwise out_zero/out_neg/out_ovf are tied to 0.
module cla_pipe_adder32
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
);

`ifdef CLA_PIPE_FLAGS_EN
  // Two's-complement overflow: like-signed operands giving a differently signed result.
  function automatic logic ovf_flag(input logic a_s, input logic b_s, input logic s_s);
    return (a_s == b_s) && (s_s != a_s);
  endfunction
`endif

  // Pipeline control
  logic    vld_p1_q, vld_p1_d;
  logic    vld_p2_q, vld_p2_d;
  logic    s2_load;
  logic    accept;

  // Payload registers
  s1_pay_t pay_p1_q, pay_p1_d;
  s2_pay_t pay_p2_q, pay_p2_d;

  // Stage-1 combinational terms
  logic [CLA_WIDTH-1:0] b_eff;
  logic [CLA_WIDTH-1:0] bit_p;
  logic [CLA_WIDTH-1:0] bit_g;
  logic [CLA_NGRP-1:0]  grp_p;
  logic [CLA_NGRP-1:0]  grp_g;
  logic [4:1]           unused_grp_c [CLA_NGRP];

  // Stage-2 combinational terms
  logic [4:1]           sec0_c;
  logic [4:1]           sec1_c;
  logic [CLA_NGRP:0]    grp_c;
  logic [4:1]           bit_c [CLA_NGRP];
  logic [CLA_WIDTH-1:0] carry_vec;
  logic [CLA_WIDTH-1:0] sum_p2;
  logic [CLA_NGRP-1:0]  unused_bit_c4;
  logic [CLA_NGRP-1:0]  unused_bit_po;
  logic [CLA_NGRP-1:0]  unused_bit_go;
  logic                 unused_sec0_po, unused_sec0_go;
  logic                 unused_sec1_po, unused_sec1_go;

  // Handshake: S2 loads when empty or draining; S1 may refill in the same cycle.
  always_comb begin
    s2_load  = !vld_p2_q || out_ready;
    in_ready = !vld_p1_q || s2_load;
    accept   = in_valid && in_ready;
    vld_p2_d = s2_load ? vld_p1_q : vld_p2_q;
    vld_p1_d = accept ? 1'b1 : (s2_load ? 1'b0 : vld_p1_q);
  end

  // ---- input -> stage 1: bit P/G and one lcu4 level for group P/G ----
  always_comb begin
    b_eff = in_sub ? ~in_b : in_b;
    bit_p = in_a ^ b_eff;
    bit_g = in_a & b_eff;
  end

  for (genvar gi = 0; gi < CLA_NGRP; gi++) begin : g_grp_pg
    lcu4 u_grp (
      .c_in  (1'b0),
      .p     (bit_p[CLA_GRP*gi +: CLA_GRP]),
      .g     (bit_g[CLA_GRP*gi +: CLA_GRP]),
      .carry (unused_grp_c[gi]),
      .p_out (grp_p[gi]),
      .g_out (grp_g[gi])
    );
  end

  // Capture stage-1 payload on an accepted beat, otherwise hold.
  always_comb begin
    pay_p1_d = pay_p1_q;
    if (accept) begin
      pay_p1_d.p     = bit_p;
      pay_p1_d.g     = bit_g;
      pay_p1_d.grp_p = grp_p;
      pay_p1_d.grp_g = grp_g;
      pay_p1_d.c0    = in_sub ? 1'b1 : in_cin;
`ifdef CLA_PIPE_FLAGS_EN
      pay_p1_d.a_msb = in_a[CLA_WIDTH-1];
      pay_p1_d.b_msb = b_eff[CLA_WIDTH-1];
`endif
    end
  end

  // ---- stage 1 -> stage 2: section lookahead, in-group carries, sum ----
  lcu4 u_sec0 (
    .c_in  (pay_p1_q.c0),
    .p     (pay_p1_q.grp_p[3:0]),
    .g     (pay_p1_q.grp_g[3:0]),
    .carry (sec0_c),
    .p_out (unused_sec0_po),
    .g_out (unused_sec0_go)
  );

  lcu4 u_sec1 (
    .c_in  (sec0_c[4]),
    .p     (pay_p1_q.grp_p[7:4]),
    .g     (pay_p1_q.grp_g[7:4]),
    .carry (sec1_c),
    .p_out (unused_sec1_po),
    .g_out (unused_sec1_go)
  );

  // Carry into each group: grp_c[k] feeds group k, grp_c[8] is the carry out.
  always_comb begin
    grp_c = {sec1_c, sec0_c, pay_p1_q.c0};
  end

  for (genvar gi = 0; gi < CLA_NGRP; gi++) begin : g_bit_c
    lcu4 u_bit (
      .c_in  (grp_c[gi]),
      .p     (pay_p1_q.p[CLA_GRP*gi +: CLA_GRP]),
      .g     (pay_p1_q.g[CLA_GRP*gi +: CLA_GRP]),
      .carry (bit_c[gi]),
      .p_out (unused_bit_po[gi]),
      .g_out (unused_bit_go[gi])
    );
  end

  // Assemble per-bit carries; each group's top carry duplicates the next group carry.
  always_comb begin
    carry_vec     = '0;
    unused_bit_c4 = '0;
    for (int gi = 0; gi < CLA_NGRP; gi++) begin
      carry_vec[CLA_GRP*gi]     = grp_c[gi];
      carry_vec[CLA_GRP*gi + 1] = bit_c[gi][1];
      carry_vec[CLA_GRP*gi + 2] = bit_c[gi][2];
      carry_vec[CLA_GRP*gi + 3] = bit_c[gi][3];
      unused_bit_c4[gi]         = bit_c[gi][4];
    end
    sum_p2 = pay_p1_q.p ^ carry_vec;
  end

  // Load the result register when stage 2 advances with a valid beat.
  always_comb begin
    pay_p2_d = pay_p2_q;
    if (s2_load && vld_p1_q) begin
      pay_p2_d.sum  = sum_p2;
      pay_p2_d.cout = grp_c[CLA_NGRP];
`ifdef CLA_PIPE_FLAGS_EN
      pay_p2_d.zero = (sum_p2 == '0);
      pay_p2_d.neg  = sum_p2[CLA_WIDTH-1];
      pay_p2_d.ovf  = ovf_flag(pay_p1_q.a_msb, pay_p1_q.b_msb, sum_p2[CLA_WIDTH-1]);
`endif
    end
  end

  // Valid bits and the visible result clear on reset; in-flight beats are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      pay_p2_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      pay_p2_q <= pay_p2_d;
    end
  end

  // Stage-1 payload is qualified by vld_p1_q and needs no reset.
  always_ff @(posedge clk) begin
    pay_p1_q <= pay_p1_d;
  end

  // ---- stage 2 -> outputs ----
  always_comb begin
    out_valid = vld_p2_q;
    out_sum   = pay_p2_q.sum;
    out_cout  = pay_p2_q.cout;
`ifdef CLA_PIPE_FLAGS_EN
    out_zero  = pay_p2_q.zero;
    out_neg   = pay_p2_q.neg;
    out_ovf   = pay_p2_q.ovf;
`else
    out_zero  = 1'b0;
    out_neg   = 1'b0;
    out_ovf   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_cla_pipe_adder32.sv
// Directed testbench for cla_pipe_adder32: single-beat vectors with
// hand-computed results, backpressure streaming, and reset mid-flight.
module tb_cla_pipe_adder32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        in_cin, in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout, out_zero, out_neg, out_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  cla_pipe_adder32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1. Beat is presented now, captured at the next edge,
  // and the result is visible after the edge after that.
  task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub, input logic [31:0] es,
                         input logic ec, input logic ez, input logic en, input logic eo);
`ifndef CLA_PIPE_FLAGS_EN
    ez = 1'b0; en = 1'b0; eo = 1'b0;
`endif
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    @(negedge clk);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_lat1_valid"}, 64'(out_valid), 64'(1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_valid"}, 64'(out_valid), 64'(1'b1));
    chk({nm, "_sum"},   64'(out_sum),   64'(es));
    chk({nm, "_cout"},  64'(out_cout),  64'(ec));
    chk({nm, "_zero"},  64'(out_zero),  64'(ez));
    chk({nm, "_neg"},   64'(out_neg),   64'(en));
    chk({nm, "_ovf"},   64'(out_ovf),   64'(eo));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] bp_exp [4];
    int tx, rx, stall_cnt, stalls;
    bit first_seen, acc, con;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_out_sum",   64'(out_sum),   64'(0));
    chk("rst_out_cout",  64'(out_cout),  64'(1'b0));
    chk("rst_flags",     64'({out_zero, out_neg, out_ovf}), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'(1'b1));
    @(posedge clk); #1;

    //        name        a             b             cin   sub   sum           cout  z     n     o
    run_one("add5p3",   32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("addchain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    run_one("addovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    run_one("sub3m5c0", 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    run_one("sub3m5c1", 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    run_one("addcin",   32'h0F0F_0F0F, 32'h10F0_F0F0, 1'b1, 1'b0, 32'h2000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("subeq",    32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    run_one("subovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);

    // Backpressure: 4 beats a=0x100+i, b=i -> sum 0x100+2i; out_ready low 3 cycles after first result.
    for (int i = 0; i < 4; i++) bp_exp[i] = 32'h100 + 32'(2 * i);
    tx = 0; rx = 0; stall_cnt = 0; stalls = 0; first_seen = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
      in_valid = (tx < 4);
      in_a = 32'h100 + 32'(tx); in_b = 32'(tx); in_cin = 1'b0; in_sub = 1'b0;
      @(negedge clk);
      if (out_valid && !out_ready) begin
        stalls++;
        chk("bp_in_ready_held", 64'(in_ready), 64'(1'b0));
        chk("bp_held_sum", 64'(out_sum), 64'(bp_exp[rx]));
      end
      acc = in_valid && in_ready;
      con = out_valid && out_ready;
      if (con) begin
        chk($sformatf("bp_sum%0d", rx), 64'(out_sum), 64'(bp_exp[rx]));
        rx++;
      end
      @(posedge clk); #1;
      if (acc) tx++;
      if (!first_seen && out_valid) begin
        first_seen = 1'b1;
        stall_cnt = 3;
      end
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = 1'b1;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_results", 64'(rx), 64'(4));
    chk("bp_stall_cycles", 64'(stalls), 64'(3));
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'(1'b0));
    @(posedge clk); #1;

    // Reset mid-flight with two beats held.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'h0000_0010; in_b = 32'h0000_0020; in_cin = 1'b0; in_sub = 1'b0;
    @(posedge clk); #1;
    in_a = 32'h0000_0030; in_b = 32'h0000_0040;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mf_valid_before", 64'(out_valid), 64'(1'b1));
    chk("mf_sum_before", 64'(out_sum), 64'(32'h0000_0030));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mf_rst_valid", 64'(out_valid), 64'(1'b0));
    chk("mf_rst_sum", 64'(out_sum), 64'(0));
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mf_rel_in_ready", 64'(in_ready), 64'(1'b1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mf_no_stale%0d", k), 64'(out_valid), 64'(1'b0));
    end
    @(posedge clk); #1;
    run_one("mf_new",   32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
